// File: rtl/serial_add_sub.sv
// Bit-serial unsigned adder/subtractor: one result bit per clock, LSB first, with a done pulse.
// Optional SERIAL_ADD_SUB_ABORT_EN adds an abort input that cancels an operation during SHIFT.
//
// state | meaning
// IDLE  | waiting for start; operands are captured on start
// SHIFT | one bit processed per cycle, WIDTH cycles in total
// DONE  | result registers valid, done pulses for one cycle
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             addSub,
`ifdef SERIAL_ADD_SUB_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             Co,
    output logic             addSubOut
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic             carry;
    logic             op_q;
    logic [CW-1:0]    cnt;
    logic             abort_req;
    logic             s_bit;
    logic             c_nxt;
    logic             last;

`ifdef SERIAL_ADD_SUB_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign s_bit = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last  = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (abort_req)  state_nxt = IDLE;
                else if (last)  state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers only load on the final SHIFT bit, so they hold through later operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            carry     <= 1'b0;
            op_q      <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            Co        <= 1'b0;
            addSubOut <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{addSub}};
                        op_q  <= addSub;
                        carry <= addSub;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (!abort_req) begin
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        s_sh  <= {s_bit, s_sh[WIDTH-1:1]};
                        carry <= c_nxt;
                        if (last) begin
                            sum       <= {s_bit, s_sh[WIDTH-1:1]};
                            Co        <= c_nxt;
                            addSubOut <= op_q;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
